// File: rtl/wb_buffer.sv
// Write-back buffer: queues ALU results in order and drains them into the register file,
// retiring scoreboard entries and applying vl/sew updates in program order.
module wb_buffer #(
  parameter int XLEN      = 32,
  parameter int VLEN      = 256,
  parameter int SB_SIZE_W = 4,
  parameter int REG_W     = 5,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  input  logic [SB_SIZE_W-1:0] wb_pos,
  input  logic [REG_W-1:0]     wb_rd,
  input  logic [VLEN-1:0]      wb_value,
  input  logic                 wb_is_vec,
  input  logic                 csr_we,
  input  logic [XLEN-1:0]      vl_set,
  input  logic [XLEN-1:0]      sew_set,
  output logic                 issue_stall,
  output logic                 rf_valid,
  input  logic                 rf_ready,
  output logic [REG_W-1:0]     rf_rd,
  output logic                 rf_is_vec,
  output logic [VLEN-1:0]      rf_value,
  output logic                 sb_done,
  output logic [SB_SIZE_W-1:0] sb_pos,
  output logic                 csr_wr,
  output logic [XLEN-1:0]      vl_out,
  output logic [XLEN-1:0]      sew_out,
  output logic                 overflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [SB_SIZE_W-1:0] r_memPos   [DEPTH];
  logic [REG_W-1:0]     r_memRd    [DEPTH];
  logic                 r_memIsVec [DEPTH];
  logic [VLEN-1:0]      r_memValue [DEPTH];
  logic                 r_memCsrWe [DEPTH];
  logic [XLEN-1:0]      r_memVl    [DEPTH];
  logic [XLEN-1:0]      r_memSew   [DEPTH];

  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_sbDone;
  logic [SB_SIZE_W-1:0] r_sbPos;
  logic                 r_csrWr;
  logic [XLEN-1:0]      r_vl;
  logic [XLEN-1:0]      r_sew;
  logic                 r_overflowErr;

  logic w_notEmpty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_overflow;

  assign w_notEmpty = (r_count != '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop      = w_notEmpty && rf_ready;
  // A full FIFO still accepts a push when the same edge pops the head.
  assign w_push     = wb_valid && (!w_full || w_pop);
  assign w_overflow = wb_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_memPos[r_wrPtr]   <= wb_pos;
      r_memRd[r_wrPtr]    <= wb_rd;
      r_memIsVec[r_wrPtr] <= wb_is_vec;
      r_memValue[r_wrPtr] <= wb_value;
      r_memCsrWe[r_wrPtr] <= csr_we;
      r_memVl[r_wrPtr]    <= vl_set;
      r_memSew[r_wrPtr]   <= sew_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_sbDone      <= 1'b0;
      r_sbPos       <= '0;
      r_csrWr       <= 1'b0;
      r_vl          <= '0;
      r_sew         <= XLEN'(8);
      r_overflowErr <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr  <= r_rdPtr + PTR_W'(1);
        r_sbDone <= 1'b1;
        r_sbPos  <= r_memPos[r_rdPtr];
        r_csrWr  <= r_memCsrWe[r_rdPtr];
        if (r_memCsrWe[r_rdPtr]) begin
          r_vl  <= r_memVl[r_rdPtr];
          r_sew <= r_memSew[r_rdPtr];
        end
      end else begin
        r_sbDone <= 1'b0;
        r_csrWr  <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_overflow) begin
        r_overflowErr <= 1'b1;
      end
    end
  end

  // Stall one entry early to leave room for the result already in the ALU pipeline register.
  assign issue_stall  = (r_count >= CNT_W'(DEPTH - 1));
  assign rf_valid     = w_notEmpty;
  assign rf_rd        = w_notEmpty ? r_memRd[r_rdPtr]    : '0;
  assign rf_is_vec    = w_notEmpty ? r_memIsVec[r_rdPtr] : 1'b0;
  assign rf_value     = w_notEmpty ? r_memValue[r_rdPtr] : '0;
  assign sb_done      = r_sbDone;
  assign sb_pos       = r_sbPos;
  assign csr_wr       = r_csrWr;
  assign vl_out       = r_vl;
  assign sew_out      = r_sew;
  assign overflow_err = r_overflowErr;

endmodule

// File: tb/tb_wb_buffer.sv
// Testbench for wb_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_wb_buffer;

  localparam int XLEN      = 32;
  localparam int VLEN      = 256;
  localparam int SB_SIZE_W = 4;
  localparam int REG_W     = 5;
  localparam int DEPTH     = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wb_valid;
  logic [SB_SIZE_W-1:0] wb_pos;
  logic [REG_W-1:0]     wb_rd;
  logic [VLEN-1:0]      wb_value;
  logic                 wb_is_vec;
  logic                 csr_we;
  logic [XLEN-1:0]      vl_set;
  logic [XLEN-1:0]      sew_set;
  logic                 issue_stall;
  logic                 rf_valid;
  logic                 rf_ready;
  logic [REG_W-1:0]     rf_rd;
  logic                 rf_is_vec;
  logic [VLEN-1:0]      rf_value;
  logic                 sb_done;
  logic [SB_SIZE_W-1:0] sb_pos;
  logic                 csr_wr;
  logic [XLEN-1:0]      vl_out;
  logic [XLEN-1:0]      sew_out;
  logic                 overflow_err;

  wb_buffer #(
    .XLEN(XLEN), .VLEN(VLEN), .SB_SIZE_W(SB_SIZE_W), .REG_W(REG_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_pos(wb_pos), .wb_rd(wb_rd), .wb_value(wb_value),
    .wb_is_vec(wb_is_vec), .csr_we(csr_we), .vl_set(vl_set), .sew_set(sew_set),
    .issue_stall(issue_stall), .rf_valid(rf_valid), .rf_ready(rf_ready),
    .rf_rd(rf_rd), .rf_is_vec(rf_is_vec), .rf_value(rf_value),
    .sb_done(sb_done), .sb_pos(sb_pos), .csr_wr(csr_wr),
    .vl_out(vl_out), .sew_out(sew_out), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SB_SIZE_W-1:0] pos;
    logic [REG_W-1:0]     rd;
    logic                 isVec;
    logic [VLEN-1:0]      value;
    logic                 csrWe;
    logic [XLEN-1:0]      vl;
    logic [XLEN-1:0]      sew;
  } entry_t;

  entry_t               mq[$];
  logic                 mSbDone = 1'b0;
  logic [SB_SIZE_W-1:0] mSbPos = '0;
  logic                 mCsrWr = 1'b0;
  logic [XLEN-1:0]      mVl = '0;
  logic [XLEN-1:0]      mSew = 32'd8;
  logic                 mOvf = 1'b0;
  bit                   checkEn = 1'b0;

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkOutput(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue; pop happens before push on the same edge.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mSbDone = 1'b0;
      mSbPos  = '0;
      mCsrWr  = 1'b0;
      mVl     = '0;
      mSew    = 32'd8;
      mOvf    = 1'b0;
    end else begin
      automatic bit wasFull = (mq.size() == DEPTH);
      automatic bit popped  = (mq.size() != 0) && rf_ready;
      if (popped) begin
        automatic entry_t h = mq.pop_front();
        mSbDone = 1'b1;
        mSbPos  = h.pos;
        mCsrWr  = h.csrWe;
        if (h.csrWe) begin
          mVl  = h.vl;
          mSew = h.sew;
        end
      end else begin
        mSbDone = 1'b0;
        mCsrWr  = 1'b0;
      end
      if (wb_valid) begin
        if (wasFull && !popped) begin
          mOvf = 1'b1;
        end else begin
          automatic entry_t e;
          e.pos = wb_pos; e.rd = wb_rd; e.isVec = wb_is_vec; e.value = wb_value;
          e.csrWe = csr_we; e.vl = vl_set; e.sew = sew_set;
          mq.push_back(e);
        end
      end
    end
  end

  // Compare every cycle on the falling edge, once the first reset has settled.
  always @(negedge clk) begin
    if (checkEn) begin
      automatic bit ne = (mq.size() != 0);
      checkOutput("rf_valid", VLEN'(rf_valid), VLEN'(ne));
      checkOutput("rf_rd", VLEN'(rf_rd), ne ? VLEN'(mq[0].rd) : '0);
      checkOutput("rf_is_vec", VLEN'(rf_is_vec), ne ? VLEN'(mq[0].isVec) : '0);
      checkOutput("rf_value", rf_value, ne ? mq[0].value : '0);
      checkOutput("issue_stall", VLEN'(issue_stall), VLEN'(mq.size() >= DEPTH - 1));
      checkOutput("sb_done", VLEN'(sb_done), VLEN'(mSbDone));
      checkOutput("sb_pos", VLEN'(sb_pos), VLEN'(mSbPos));
      checkOutput("csr_wr", VLEN'(csr_wr), VLEN'(mCsrWr));
      checkOutput("vl_out", VLEN'(vl_out), VLEN'(mVl));
      checkOutput("sew_out", VLEN'(sew_out), VLEN'(mSew));
      checkOutput("overflow_err", VLEN'(overflow_err), VLEN'(mOvf));
    end
  end

  // Drive one cycle of inputs, let the edge happen, and return 1 time unit after it.
  task automatic applyStimulus(input logic v, input int pos, input int rd, input logic [VLEN-1:0] val,
                               input logic isVec, input logic we, input int vl, input int sew,
                               input logic ready);
    wb_valid  = v;
    wb_pos    = SB_SIZE_W'(pos);
    wb_rd     = REG_W'(rd);
    wb_value  = val;
    wb_is_vec = isVec;
    csr_we    = we;
    vl_set    = XLEN'(vl);
    sew_set   = XLEN'(sew);
    rf_ready  = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ready);
    applyStimulus(1'b0, 0, 0, '0, 1'b0, 1'b0, 0, 0, ready);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle(1'b0);
    doReset();
    checkEn = 1'b1;
    checkOutput("reset rf_valid", VLEN'(rf_valid), '0);
    checkOutput("reset sew_out", VLEN'(sew_out), VLEN'(8));
    checkOutput("reset vl_out", VLEN'(vl_out), '0);
    checkOutput("reset issue_stall", VLEN'(issue_stall), '0);

    // Single scalar push with the register file ready.
    applyStimulus(1'b1, 3, 5, VLEN'(32'h1234), 1'b0, 1'b0, 0, 0, 1'b1);
    checkOutput("single rf_valid", VLEN'(rf_valid), VLEN'(1));
    checkOutput("single rf_rd", VLEN'(rf_rd), VLEN'(5));
    checkOutput("single rf_value", rf_value, VLEN'(32'h1234));
    idle(1'b1);
    checkOutput("single sb_done", VLEN'(sb_done), VLEN'(1));
    checkOutput("single sb_pos", VLEN'(sb_pos), VLEN'(3));
    checkOutput("single csr_wr", VLEN'(csr_wr), '0);
    checkOutput("single empty", VLEN'(rf_valid), '0);
    idle(1'b1);
    checkOutput("single pulse ends", VLEN'(sb_done), '0);

    // Backpressure fill with pos 0..3.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i, i + 10, VLEN'(i + 100), 1'b0, 1'b0, 0, 0, 1'b0);
      if (i == 1) checkOutput("stall after 2", VLEN'(issue_stall), '0);
      if (i == 2) checkOutput("stall after 3", VLEN'(issue_stall), VLEN'(1));
    end
    checkOutput("full head rd", VLEN'(rf_rd), VLEN'(10));
    checkOutput("full head value", rf_value, VLEN'(100));

    // Simultaneous push and pop while full.
    applyStimulus(1'b1, 4, 14, VLEN'(104), 1'b1, 1'b0, 0, 0, 1'b1);
    checkOutput("simul sb_pos", VLEN'(sb_pos), VLEN'(0));
    checkOutput("simul overflow", VLEN'(overflow_err), '0);
    checkOutput("simul stall", VLEN'(issue_stall), VLEN'(1));
    checkOutput("simul head rd", VLEN'(rf_rd), VLEN'(11));

    // Overflow: full, no pop; pos 9 must be dropped.
    applyStimulus(1'b1, 9, 19, VLEN'(109), 1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("overflow flag", VLEN'(overflow_err), VLEN'(1));
    checkOutput("overflow head rd", VLEN'(rf_rd), VLEN'(11));
    for (int i = 1; i <= 4; i++) begin
      idle(1'b1);
      checkOutput("drain sb_pos", VLEN'(sb_pos), VLEN'(i));
      checkOutput("drain sb_done", VLEN'(sb_done), VLEN'(1));
    end
    checkOutput("drain last is_vec", VLEN'(rf_valid), '0);
    idle(1'b1);
    checkOutput("overflow sticky", VLEN'(overflow_err), VLEN'(1));
    checkOutput("drain done", VLEN'(sb_done), '0);

    // CSR ordering.
    doReset();
    checkOutput("ovf cleared", VLEN'(overflow_err), '0);
    applyStimulus(1'b1, 1, 2, {VLEN{1'b1}}, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b1, 2, 0, '0, 1'b0, 1'b1, 8, 32, 1'b0);
    applyStimulus(1'b1, 3, 7, VLEN'(32'hABCD), 1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("vec head is_vec", VLEN'(rf_is_vec), VLEN'(1));
    idle(1'b1);
    checkOutput("pos1 csr_wr", VLEN'(csr_wr), '0);
    checkOutput("pos1 sew_out", VLEN'(sew_out), VLEN'(8));
    idle(1'b1);
    checkOutput("pos2 csr_wr", VLEN'(csr_wr), VLEN'(1));
    checkOutput("pos2 vl_out", VLEN'(vl_out), VLEN'(8));
    checkOutput("pos2 sew_out", VLEN'(sew_out), VLEN'(32));
    idle(1'b1);
    checkOutput("pos3 sb_pos", VLEN'(sb_pos), VLEN'(3));
    checkOutput("pos3 csr_wr", VLEN'(csr_wr), '0);
    checkOutput("pos3 vl_out", VLEN'(vl_out), VLEN'(8));
    idle(1'b1);

    // Reset mid-operation with a concurrent push and ready.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, i + 5, i + 1, VLEN'(i + 50), 1'b0, 1'b1, 4, 16, 1'b0);
    end
    checkOutput("pre-reset stall", VLEN'(issue_stall), VLEN'(1));
    rst = 1'b1;
    applyStimulus(1'b1, 12, 12, VLEN'(12), 1'b0, 1'b1, 99, 99, 1'b1);
    rst = 1'b0;
    checkOutput("rst rf_valid", VLEN'(rf_valid), '0);
    checkOutput("rst stall", VLEN'(issue_stall), '0);
    checkOutput("rst sb_done", VLEN'(sb_done), '0);
    checkOutput("rst csr_wr", VLEN'(csr_wr), '0);
    checkOutput("rst sew_out", VLEN'(sew_out), VLEN'(8));
    idle(1'b1);
    checkOutput("rst no pop", VLEN'(sb_done), '0);

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 31),
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                    $urandom_range(1, 64), 8 << $urandom_range(0, 3),
                    1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
